// File: rtl/proc_io_pkg.sv
// Shared constants and types for the processor I/O front-end blocks.
// DEBOUNCE_HW is 1 ms at the 50 MHz board clock.
package proc_io_pkg;

  localparam int GPIO_W       = 8;
  localparam int DEBOUNCE_SIM = 4;
  localparam int DEBOUNCE_HW  = 50_000;

  typedef enum logic {
    DB_STABLE  = 1'b0,
    DB_PENDING = 1'b1
  } db_state_e;

  // Counter must hold values 0 .. cycles-1 without ever wrapping.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/gpi_debounce_bit.sv
// One input bit: 2-flop synchroniser, debounce counter, accepted level and edge strobes.
module gpi_debounce_bit
  import proc_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic rise_nxt_o
);

  localparam int                CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  db_state_e        state_s;

  // A bounce back to the accepted level drops the count with no partial credit.
  always_comb begin
    level_d = level_q;
    cnt_d   = {CNT_W{1'b0}};
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    state_s = (s2_q != level_q) ? DB_PENDING : DB_STABLE;
    case (state_s)
      DB_STABLE: begin
        cnt_d = {CNT_W{1'b0}};
      end
      DB_PENDING: begin
        if (cnt_q == CNT_LAST) begin
          level_d = s2_q;
          rise_d  = s2_q;
          fall_d  = ~s2_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d = {CNT_W{1'b0}};
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      s1_q    <= pin_i;
      s2_q    <= s1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o    = level_q;
  assign rise_o     = rise_q;
  assign fall_o     = fall_q;
  assign rise_nxt_o = rise_d;

endmodule

// File: rtl/gpi_conditioner.sv
// Debounced GPI front-end: per-bit conditioning plus sticky rise-event flags for polling software.
module gpi_conditioner
  import proc_io_pkg::*;
#(
  parameter int WIDTH           = GPIO_W,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pin_in,
  input  logic [WIDTH-1:0] ev_ack,
  output logic [WIDTH-1:0] gpi,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] ev_pending
);

  logic [WIDTH-1:0] rise_nxt_s;
  logic [WIDTH-1:0] ev_pending_d, ev_pending_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpi_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk       (clk),
      .rst_n     (rst_n),
      .pin_i     (pin_in[i]),
      .level_o   (gpi[i]),
      .rise_o    (rise[i]),
      .fall_o    (fall[i]),
      .rise_nxt_o(rise_nxt_s[i])
    );
  end

  // A rise in the same cycle as an ack keeps the flag set.
  always_comb begin
    ev_pending_d = rise_nxt_s | (ev_pending_q & ~ev_ack);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_pending_q <= {WIDTH{1'b0}};
    end else begin
      ev_pending_q <= ev_pending_d;
    end
  end

  assign ev_pending = ev_pending_q;

endmodule

// File: tb/tb_gpi_conditioner.sv
// Self-checking bench: sliding-window reference model, directed scenarios, then randomized pins/acks/resets.
module tb_gpi_conditioner;

  localparam int D = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] pin_in;
  logic [7:0] ev_ack;
  logic [7:0] gpi, rise, fall, ev_pending;

  int total = 0;
  int bad   = 0;

  // Model: pin samples per edge; gpi flips when the last D synchronised samples all disagree with it.
  logic [7:0] hist[$];
  logic [7:0] m_gpi, m_rise, m_fall, m_ev;

  gpi_conditioner #(
    .WIDTH(8),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pin_in    (pin_in),
    .ev_ack    (ev_ack),
    .gpi       (gpi),
    .rise      (rise),
    .fall      (fall),
    .ev_pending(ev_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < D + 2; k++) hist.push_back(8'h00);
    m_gpi  = 8'h00;
    m_rise = 8'h00;
    m_fall = 8'h00;
    m_ev   = 8'h00;
  endtask

  // The synchroniser output after edge m equals the pin sampled at edge m-1, so the
  // window deciding edge n is the pins sampled at edges n-D-1 .. n-2.
  task automatic model_edge();
    logic [7:0] flip;
    hist.push_back(pin_in);
    if (hist.size() > D + 2) void'(hist.pop_front());
    flip = 8'hFF;
    for (int j = 2; j <= D + 1; j++) begin
      flip &= (hist[hist.size() - 1 - j] ^ m_gpi);
    end
    m_rise = flip & ~m_gpi;
    m_fall = flip & m_gpi;
    m_gpi  = m_gpi ^ flip;
    m_ev   = m_rise | (m_ev & ~ev_ack);
  endtask

  task automatic compare_all();
    chk("gpi", gpi, m_gpi);
    chk("rise", rise, m_rise);
    chk("fall", fall, m_fall);
    chk("ev_pending", ev_pending, m_ev);
  endtask

  // Called from a falling edge: drive, advance one rising edge, compare on the next falling edge.
  task automatic step(input logic [7:0] p, input logic [7:0] a);
    pin_in = p;
    ev_ack = a;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic mid_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_gpi", gpi, 8'h00);
    chk("rst_rise", rise, 8'h00);
    chk("rst_fall", fall, 8'h00);
    chk("rst_ev", ev_pending, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] cur;
    logic [7:0] p;
    rst_n  = 1'b0;
    pin_in = 8'h00;
    ev_ack = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_gpi", gpi, 8'h00);
    chk("reset_rise", rise, 8'h00);
    chk("reset_fall", fall, 8'h00);
    chk("reset_ev", ev_pending, 8'h00);
    rst_n = 1'b1;

    // Latency: pin before edge 0 -> gpi after edge 5.
    for (int i = 0; i < 8; i++) begin
      step(8'h01, 8'h00);
      chk("lat_gpi", gpi, (i >= 5) ? 8'h01 : 8'h00);
      chk("lat_rise", rise, (i == 5) ? 8'h01 : 8'h00);
      chk("lat_ev", ev_pending, (i >= 5) ? 8'h01 : 8'h00);
    end
    step(8'h01, 8'h01);
    chk("ack_clear", ev_pending, 8'h00);

    // Return to 0 then a 3-cycle pulse on bit 1 must be filtered.
    for (int i = 0; i < 8; i++) step(8'h00, 8'h00);
    chk("back_to_zero", gpi, 8'h00);
    for (int i = 0; i < 12; i++) begin
      step((i < 3) ? 8'h02 : 8'h00, 8'h00);
      chk("short_gpi", gpi, 8'h00);
      chk("short_rise", rise, 8'h00);
      chk("short_fall", fall, 8'h00);
    end

    // Bounce 1,0,1,1,... on bit 0: single rise at edge 7.
    for (int i = 0; i < 10; i++) begin
      step((i == 1) ? 8'h00 : 8'h01, 8'h00);
      chk("bounce_gpi", gpi, (i >= 7) ? 8'h01 : 8'h00);
      chk("bounce_rise", rise, (i == 7) ? 8'h01 : 8'h00);
    end

    // Simultaneous fall on bit 0 and rise on bit 1.
    for (int i = 0; i < 7; i++) begin
      step(8'h02, 8'h00);
      chk("swap_gpi", gpi, (i >= 5) ? 8'h02 : 8'h01);
      chk("swap_rise", rise, (i == 5) ? 8'h02 : 8'h00);
      chk("swap_fall", fall, (i == 5) ? 8'h01 : 8'h00);
    end

    // Bit 1 falls (flag kept), rises again with ack on that very cycle: flag stays.
    for (int i = 0; i < 8; i++) step(8'h00, 8'h00);
    chk("ev_kept", ev_pending & 8'h02, 8'h02);
    for (int i = 0; i < 5; i++) step(8'h02, 8'h00);
    step(8'h02, 8'h02);
    chk("set_wins_rise", rise, 8'h02);
    chk("set_wins_ev", ev_pending & 8'h02, 8'h02);
    step(8'h02, 8'h02);
    chk("ack_alone", ev_pending & 8'h02, 8'h00);

    // Reset with bit 0 counter at 3, pins held high through release.
    for (int i = 0; i < 5; i++) step(8'h03, 8'h00);
    mid_reset();
    for (int i = 0; i < 8; i++) begin
      step(8'h03, 8'h00);
      chk("post_rst_rise", rise, (i == 5) ? 8'h03 : 8'h00);
    end

    // Randomized phase: sparse per-bit toggles, sparse acks, rare resets.
    cur = 8'h00;
    for (int n = 0; n < 4000; n++) begin
      p = cur;
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 9) == 0) p[b] = ~p[b];
      end
      cur = p;
      if ($urandom_range(0, 599) == 0) begin
        mid_reset();
      end else begin
        step(cur, 8'($urandom) & 8'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpi_conditioner.md
# gpi_conditioner

Input front-end for the `procesor` core: takes raw asynchronous pin levels (buttons/switches) and drives the core's 8-bit `gpi` bus with synchronised, debounced levels. It also produces one-cycle rise/fall strobes and sticky per-bit event flags, so software polling `gpi` cannot miss short presses. It sits directly upstream of `procesor.gpi`, in the same clock domain.

## Interface
- `WIDTH`, 8, number of input bits (matches `gpi` width of the core)
- `DEBOUNCE_CYCLES`, 16, consecutive stable cycles required to accept a new level; legal range ≥ 1
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `pin_in`  in  WIDTH  raw pin levels, asynchronous to `clk`
- `ev_ack`  in  WIDTH  per-bit clear for `ev_pending`, sampled on `clk`
- `gpi`  out  WIDTH  debounced level, connects to `procesor.gpi`
- `rise`  out  WIDTH  one-cycle strobe when a `gpi` bit goes 0→1
- `fall`  out  WIDTH  one-cycle strobe when a `gpi` bit goes 1→0
- `ev_pending`  out  WIDTH  sticky flag, set by `rise`, cleared by `ev_ack`

## Operation
- Per bit, fully independent: 2-flop synchroniser (`s1`, `s2`), stable-level register (drives `gpi`), counter `cnt` of width `$clog2(DEBOUNCE_CYCLES+1)`.
- Per bit, two states: STABLE (`s2 == gpi`) and PENDING (`s2 != gpi`).
  - STABLE: `cnt` held at 0.
  - PENDING: `cnt` increments each cycle; on the edge where `cnt` would reach `DEBOUNCE_CYCLES`, `gpi` takes `s2`, `cnt` returns to 0.
  - Any return of `s2` to `gpi` before completion resets `cnt` to 0 (bounce restarts the count, with no partial credit).
- `rise`/`fall`: registered, asserted in the same cycle `gpi` changes, deasserted the next cycle.
- `ev_pending[i]`: next = `rise[i]` next-value OR (`ev_pending[i]` AND NOT `ev_ack[i]`). Set and ack in the same cycle leaves the flag set (set wins).
- Counter never wraps: saturation is impossible because it clears on acceptance.

## Timing
- Reset (`rst_n` low, async assert): `s1`, `s2`, `gpi`, `cnt`, `rise`, `fall`, `ev_pending` all 0. Release is synchronous to the next `clk` edge; the bench releases away from the clock edge.
- Latency: pin change set up before edge k gives `gpi`/strobe change after edge k+1+`DEBOUNCE_CYCLES`, i.e. `DEBOUNCE_CYCLES`+2 cycles.
- A pulse on `s2` shorter than `DEBOUNCE_CYCLES` cycles has no effect on any output.
- Bits changing on the same edge update `gpi` on the same edge. Both `rise` and `fall` may be non-zero in one cycle on different bits.
- A pin held high through reset release produces a normal `rise` after `DEBOUNCE_CYCLES`+2 cycles, because the post-reset level is 0.
- Reset mid-count discards all progress. `ev_pending` is lost on reset.
- `ev_ack` has single-cycle effect; holding it high keeps the flag clear except on cycles with `rise`.

## Structure
- Shared package `proc_io_pkg`: `GPIO_W = 8`, `DEBOUNCE_SIM = 4`, `DEBOUNCE_HW` (board value, 1 ms at board clock).
- Sub-module `gpi_debounce_bit` (one bit: synchroniser, counter, stable register, rise/fall). It is instantiated `WIDTH` times via generate. The `ev_pending` logic lives in the top level.
- In the top-level test wrapper, `gpi_conditioner.gpi` is wired to `procesor.gpi`, and the stimulus drives `pin_in`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES = 4`.
- Reset, then `pin_in` = 0x01 from edge 0 → `gpi` = 0x01 after edge 5 (6 cycles), `rise` = 0x01 for exactly one cycle, `ev_pending` = 0x01.
- Bit 1 high for 3 cycles then low, from `gpi` = 0x00 → `gpi`, `rise`, `fall` stay 0x00 throughout.
- Bounce: bit 0 toggles 1,0,1,1,1,1 per cycle → single `rise`, 6 cycles after the last 0→1 transition; no intermediate change.
- `pin_in` 0x01→0x02 on one edge → `gpi` 0x01→0x02 on one edge, with `fall` = 0x01 and `rise` = 0x02 in the same cycle.
- `ev_pending[1]` set, `ev_ack[1]` = 1 on the same cycle as a new `rise[1]` → flag stays 1. Ack on the next cycle alone → flag 0.
- `rst_n` low with `cnt` = 3 on bit 0 → all outputs 0 immediately. After release, with the pin still high, `rise` occurs 6 cycles later.
